// File: rtl/clic_tb_pkg.sv
// CLIC target shared types: privilege modes, arbitration candidate,
// target FSM states and the level / priority helper functions.
package clic_tb_pkg;

  // Candidate id field is sized for the largest supported source count;
  // the target narrows it to its own SRC_W when registering an offer.
  localparam int CLIC_ID_W = 16;

  typedef enum logic [1:0] {
    MODE_U = 2'b00,
    MODE_S = 2'b01,
    MODE_M = 2'b11
  } mode_t;

  typedef struct packed {
    logic                 valid;
    logic [CLIC_ID_W-1:0] id;
    mode_t                priv;
    logic [7:0]           intctl;
    logic                 shv;
  } clic_cand_t;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    RETIRE
  } clic_tgt_state_e;

  // Reserved encoding 2'b10 collapses to U.
  function automatic mode_t clic_mode(input logic [1:0] p);
    unique case (p)
      2'b11:   return MODE_M;
      2'b01:   return MODE_S;
      default: return MODE_U;
    endcase
  endfunction

  // Keep the top nlbits of intctl, fill the rest with ones.
  function automatic logic [7:0] clic_level(
    input logic [7:0] intctl,
    input logic [3:0] nlbits
  );
    logic [3:0] n;
    n = (nlbits > 4'd8) ? 4'd8 : nlbits;
    return intctl | (8'hFF >> n);
  endfunction

  // True when a strictly outranks b: priv, then intctl, then lower id.
  function automatic logic clic_beats(
    input clic_cand_t a,
    input clic_cand_t b
  );
    if (!a.valid) return 1'b0;
    if (!b.valid) return 1'b1;
    if (a.priv != b.priv) return a.priv > b.priv;
    if (a.intctl != b.intctl) return a.intctl > b.intctl;
    return a.id < b.id;
  endfunction

endpackage

// File: rtl/clic_arb_tree.sv
// Balanced comparator tree picking the best CLIC candidate.
// cand_i: one candidate per source; win_o: winner (valid=0 if none).
module clic_arb_tree
  import clic_tb_pkg::*;
#(
  parameter int N_SOURCE = 256
) (
  input  clic_cand_t [N_SOURCE-1:0] cand_i,
  output clic_cand_t                win_o
);

  localparam int LVL = $clog2(N_SOURCE);
  localparam int P   = 1 << LVL;

  clic_cand_t [P-1:0] leaf;

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < N_SOURCE) begin : g_real
      assign leaf[k] = cand_i[k];
    end else begin : g_pad
      assign leaf[k] = '0;
    end
  end

  // Left operand always covers lower ids, so it keeps ties.
  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int W = P >> (l + 1);
    clic_cand_t [W-1:0] w;
    for (genvar j = 0; j < W; j++) begin : g_node
      clic_cand_t a;
      clic_cand_t b;
      if (l == 0) begin : g_first
        assign a = leaf[2*j];
        assign b = leaf[2*j+1];
      end else begin : g_inner
        assign a = g_lvl[l-1].w[2*j];
        assign b = g_lvl[l-1].w[2*j+1];
      end
      assign w[j] = clic_beats(b, a) ? b : a;
    end
  end

  assign win_o = g_lvl[LVL-1].w[0];

endmodule

// File: rtl/clic_target.sv
// CLIC target: pending bits, arbitration and valid/ready offer to the hart.
// Sources/config in; ip_o status; clic_irq_* offer channel out.
module clic_target
  import clic_tb_pkg::*;
#(
  parameter  int N_SOURCE   = 256,
  parameter  int INTCTLBITS = 8,
  localparam int SRC_W      = $clog2(N_SOURCE)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_SOURCE-1:0]     intr_src_i,
  input  logic [N_SOURCE-1:0]     ie_i,
  input  logic [N_SOURCE-1:0]     trig_edge_i,
  input  logic [N_SOURCE*8-1:0]   intctl_i,
  input  logic [N_SOURCE-1:0]     shv_i,
  input  logic [N_SOURCE*2-1:0]   priv_i,
  input  logic [3:0]              nlbits_i,
  output logic [N_SOURCE-1:0]     ip_o,
  output logic                    clic_irq_valid_o,
  input  logic                    clic_irq_ready_i,
  output logic [SRC_W-1:0]        clic_irq_id_o,
  output logic [7:0]              clic_irq_level_o,
  output logic                    clic_irq_shv_o,
  output logic [1:0]              clic_irq_priv_o
);

  // Unimplemented intctl LSBs read as one.
  localparam logic [7:0] CTL_ONES = 8'(8'hFF >> INTCTLBITS);

  logic [N_SOURCE-1:0] src_q;
  logic [N_SOURCE-1:0] pend_q;
  logic [N_SOURCE-1:0] pend_d;
  logic [N_SOURCE-1:0] elig;
  logic [N_SOURCE-1:0] clr;

  clic_cand_t [N_SOURCE-1:0] cand;
  clic_cand_t                win;
  clic_cand_t                off;

  clic_tgt_state_e   state_q;
  logic              valid_q;
  logic [SRC_W-1:0]  id_q;
  mode_t             priv_q;
  logic [7:0]        ctl_q;
  logic [7:0]        level_q;
  logic              shv_q;
  logic              hs;

  assign elig = pend_q & ie_i;
  assign hs   = valid_q & clic_irq_ready_i;

  always_comb begin
    clr = '0;
    if (hs) clr[id_q] = trig_edge_i[id_q];
  end

  // Edge: a new rising edge beats a same-cycle claim.
  // Level: pending simply follows the line.
  always_comb begin
    pend_d = (trig_edge_i & ((intr_src_i & ~src_q) | (pend_q & ~clr)))
           | (~trig_edge_i & intr_src_i);
  end

  always_comb begin
    for (int k = 0; k < N_SOURCE; k++) begin
      cand[k].valid  = elig[k];
      cand[k].id     = CLIC_ID_W'(k);
      cand[k].priv   = clic_mode(priv_i[2*k +: 2]);
      cand[k].intctl = intctl_i[8*k +: 8] | CTL_ONES;
      cand[k].shv    = shv_i[k];
    end
  end

  // Snapshot of the current offer, ranked against the live winner.
  always_comb begin
    off.valid  = 1'b1;
    off.id     = CLIC_ID_W'(id_q);
    off.priv   = priv_q;
    off.intctl = ctl_q;
    off.shv    = shv_q;
  end

  clic_arb_tree #(
    .N_SOURCE (N_SOURCE)
  ) u_arb (
    .cand_i (cand),
    .win_o  (win)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= intr_src_i;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      priv_q  <= MODE_U;
      ctl_q   <= '0;
      level_q <= '0;
      shv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win.valid) begin
            id_q    <= win.id[SRC_W-1:0];
            priv_q  <= win.priv;
            ctl_q   <= win.intctl;
            shv_q   <= win.shv;
            level_q <= clic_level(win.intctl, nlbits_i);
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (clic_irq_ready_i) begin
            valid_q <= 1'b0;
            state_q <= RETIRE;
          end else if (clic_beats(win, off)) begin
            id_q    <= win.id[SRC_W-1:0];
            priv_q  <= win.priv;
            ctl_q   <= win.intctl;
            shv_q   <= win.shv;
            level_q <= clic_level(win.intctl, nlbits_i);
          end else if (!elig[id_q]) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        RETIRE: begin
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ip_o             = pend_q;
  assign clic_irq_valid_o = valid_q;
  assign clic_irq_id_o    = id_q;
  assign clic_irq_level_o = level_q;
  assign clic_irq_shv_o   = shv_q;
  assign clic_irq_priv_o  = priv_q;

endmodule

// File: tb/tb_clic_target.sv
// Testbench for clic_target: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_clic_target;

  localparam int N = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     src, ie, te, shv;
  logic [8*N-1:0]   ctl;
  logic [2*N-1:0]   pv;
  logic [3:0]       nlb;
  logic             rdy;

  logic [N-1:0]     ip;
  logic             vld;
  logic [3:0]       id;
  logic [7:0]       lvl;
  logic             shv_o;
  logic [1:0]       pr_o;

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [N-1:0] m_pend;
  logic [N-1:0] m_src;
  logic         m_valid;
  logic         m_bubble;
  int           m_id;
  logic [7:0]   m_ctl;
  logic [7:0]   m_lvl;
  logic [1:0]   m_priv;
  logic         m_shv;

  always #5 clk = ~clk;

  clic_target #(
    .N_SOURCE   (N),
    .INTCTLBITS (8)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .intr_src_i       (src),
    .ie_i             (ie),
    .trig_edge_i      (te),
    .intctl_i         (ctl),
    .shv_i            (shv),
    .priv_i           (pv),
    .nlbits_i         (nlb),
    .ip_o             (ip),
    .clic_irq_valid_o (vld),
    .clic_irq_ready_i (rdy),
    .clic_irq_id_o    (id),
    .clic_irq_level_o (lvl),
    .clic_irq_shv_o   (shv_o),
    .clic_irq_priv_o  (pr_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rank_of(input logic [1:0] p);
    if (p == 2'b11) return 2;
    if (p == 2'b01) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] mode_of(input logic [1:0] p);
    return (p == 2'b11) ? 2'b11 : (p == 2'b01) ? 2'b01 : 2'b00;
  endfunction

  // Larger key = more urgent; low byte makes smaller ids win ties.
  function automatic int key_of(input int r, input int c, input int k);
    return r * 65536 + c * 256 + (255 - k);
  endfunction

  function automatic logic [7:0] exp_level(input logic [7:0] c,
                                           input logic [3:0] nl);
    int keep;
    logic [7:0] r;
    keep = (nl > 4'd8) ? 8 : int'(nl);
    for (int b = 0; b < 8; b++) r[b] = (b >= 8 - keep) ? c[b] : 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_pend   = '0;
    m_src    = '0;
    m_valid  = 1'b0;
    m_bubble = 1'b0;
    m_id     = 0;
    m_ctl    = '0;
    m_lvl    = '0;
    m_priv   = '0;
    m_shv    = 1'b0;
  endtask

  task automatic load(input int k);
    m_id   = k;
    m_ctl  = ctl[8*k +: 8];
    m_priv = mode_of(pv[2*k +: 2]);
    m_shv  = shv[k];
    m_lvl  = exp_level(ctl[8*k +: 8], nlb);
  endtask

  // One clock edge of the reference behaviour, using current inputs.
  task automatic model_step();
    int best, bkey, kk;
    logic hs;
    logic [N-1:0] np;
    best = -1;
    bkey = -1;
    for (int k = 0; k < N; k++) begin
      if (m_pend[k] && ie[k]) begin
        kk = key_of(rank_of(pv[2*k +: 2]), int'(ctl[8*k +: 8]), k);
        if (kk > bkey) begin
          bkey = kk;
          best = k;
        end
      end
    end
    hs = m_valid && rdy;
    for (int k = 0; k < N; k++) begin
      if (te[k])
        np[k] = (src[k] && !m_src[k]) || (m_pend[k] && !(hs && m_id == k));
      else
        np[k] = src[k];
    end
    if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (!m_valid) begin
      if (best >= 0) begin
        load(best);
        m_valid = 1'b1;
      end
    end else if (hs) begin
      m_valid  = 1'b0;
      m_bubble = 1'b1;
    end else if (best >= 0 &&
                 bkey > key_of(rank_of(m_priv), int'(m_ctl), m_id)) begin
      load(best);
    end else if (!(m_pend[m_id] && ie[m_id])) begin
      m_valid = 1'b0;
    end
    m_pend = np;
    m_src  = src;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("ip", 32'(ip), 32'(m_pend));
    chk("valid", 32'(vld), 32'(m_valid));
    if (m_valid) begin
      chk("id", 32'(id), 32'(m_id));
      chk("level", 32'(lvl), 32'(m_lvl));
      chk("shv", 32'(shv_o), 32'(m_shv));
      chk("priv", 32'(pr_o), 32'(m_priv));
    end
  endtask

  // Async pulse between edges; no clock edge is consumed.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_ip", 32'(ip), 32'd0);
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic cfg(input int k, input logic e, input logic en,
                     input logic [7:0] c, input logic [1:0] p,
                     input logic s);
    te[k]          = e;
    ie[k]          = en;
    ctl[8*k +: 8]  = c;
    pv[2*k +: 2]   = p;
    shv[k]         = s;
  endtask

  task automatic quiesce();
    src = '0;
    ie  = '0;
    rdy = 1'b0;
    repeat (4) tick();
  endtask

  task automatic claim();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src = '0; ie = '0; te = '0; shv = '0;
    ctl = '0; pv = '0; nlb = 4'd0; rdy = 1'b0;
    model_reset();
    #1;
    chk("reset_valid", 32'(vld), 32'd0);
    chk("reset_ip", 32'(ip), 32'd0);
    chk("reset_id", 32'(id), 32'd0);
    chk("reset_level", 32'(lvl), 32'd0);
    chk("reset_priv", 32'(pr_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single edge pulse, level 0x8F
    nlb = 4'd4;
    cfg(5, 1'b1, 1'b1, 8'h80, 2'b11, 1'b1);
    src[5] = 1'b1;
    tick();
    src[5] = 1'b0;
    tick();
    chk("t1_valid", 32'(vld), 32'd1);
    chk("t1_id", 32'(id), 32'd5);
    chk("t1_level", 32'(lvl), 32'h8F);
    chk("t1_priv", 32'(pr_o), 32'd3);
    claim();
    chk("t1_ip5", 32'(ip[5]), 32'd0);
    chk("t1_drop", 32'(vld), 32'd0);
    repeat (3) tick();
    chk("t1_noreoffer", 32'(vld), 32'd0);
    quiesce();

    // higher intctl first, then RETIRE bubble
    cfg(3, 1'b1, 1'b1, 8'h40, 2'b11, 1'b0);
    cfg(9, 1'b1, 1'b1, 8'hC0, 2'b11, 1'b0);
    src[3] = 1'b1; src[9] = 1'b1;
    tick();
    src = '0;
    tick();
    chk("t2_first", 32'(id), 32'd9);
    claim();
    tick();
    chk("t2_bubble", 32'(vld), 32'd0);
    tick();
    chk("t2_second", 32'(id), 32'd3);
    claim();
    quiesce();

    // id tie-break, then priv over intctl
    cfg(4, 1'b1, 1'b1, 8'h80, 2'b11, 1'b0);
    cfg(7, 1'b1, 1'b1, 8'h80, 2'b11, 1'b0);
    src[4] = 1'b1; src[7] = 1'b1;
    tick();
    src = '0;
    tick();
    chk("t3_tie", 32'(id), 32'd4);
    claim();
    repeat (2) tick();
    claim();
    quiesce();
    cfg(2, 1'b1, 1'b1, 8'hFF, 2'b01, 1'b0);
    cfg(8, 1'b1, 1'b1, 8'h00, 2'b11, 1'b0);
    src[2] = 1'b1; src[8] = 1'b1;
    tick();
    src = '0;
    tick();
    chk("t3_priv", 32'(id), 32'd8);
    claim();
    repeat (2) tick();
    claim();
    quiesce();

    // preemption with ready low
    cfg(10, 1'b1, 1'b1, 8'h40, 2'b11, 1'b0);
    src[10] = 1'b1;
    tick();
    src = '0;
    tick();
    chk("t4_first", 32'(id), 32'd10);
    cfg(11, 1'b1, 1'b1, 8'hA0, 2'b11, 1'b0);
    src[11] = 1'b1;
    tick();
    src = '0;
    chk("t4_hold", 32'(vld), 32'd1);
    tick();
    chk("t4_switch", 32'(id), 32'd11);
    claim();
    repeat (2) tick();
    chk("t4_back", 32'(id), 32'd10);
    claim();
    quiesce();

    // level source
    cfg(12, 1'b0, 1'b1, 8'h60, 2'b11, 1'b0);
    src[12] = 1'b1;
    repeat (2) tick();
    chk("t5_offer", 32'(id), 32'd12);
    claim();
    chk("t5_ip_kept", 32'(ip[12]), 32'd1);
    repeat (2) tick();
    chk("t5_reoffer", 32'(vld), 32'd1);
    src[12] = 1'b0;
    repeat (2) tick();
    chk("t5_dropped", 32'(vld), 32'd0);
    quiesce();

    // new edge during the claim cycle
    cfg(5, 1'b1, 1'b1, 8'h80, 2'b11, 1'b0);
    src[5] = 1'b1;
    tick();
    src[5] = 1'b0;
    tick();
    src[5] = 1'b1;
    claim();
    src[5] = 1'b0;
    chk("t6_setwins", 32'(ip[5]), 32'd1);
    repeat (2) tick();
    claim();
    quiesce();

    // async reset mid-offer
    cfg(6, 1'b1, 1'b1, 8'h80, 2'b11, 1'b0);
    src[6] = 1'b1;
    tick();
    src[6] = 1'b0;
    tick();
    chk("t7_offer", 32'(vld), 32'd1);
    do_reset();
    repeat (3) tick();
    chk("t7_nostale", 32'(vld), 32'd0);
    quiesce();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        ie  = N'($urandom);
        te  = N'($urandom);
        shv = N'($urandom);
        pv  = 32'($urandom);
        ctl = {$urandom, $urandom, $urandom, $urandom};
        nlb = 4'($urandom_range(0, 15));
      end
      src = src ^ N'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
